tcam_7x64: RTL and testbench
============================

TCAM_7X64 -- requirements
Module: tcam_7x64

Interface
REQ-001 Parameter ROWS, default 128, number of search-key rows (7-bit key space); fixed, not overridable.
REQ-002 Parameter MATCH_W, default 64, stored entries, i.e. match-vector width; fixed.
REQ-003 Parameter DATA_W, default 32, write-data width (one half-row per write); fixed.
REQ-004 in_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 in_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_csb  input  1  chip select, active-low; 1 = idle.
REQ-007 in_web  input  1  write enable, active-low; 0 = write, 1 = search.
REQ-008 in_wmask  input  4  byte-lane write enables for in_wdata.
REQ-009 in_addr  input  8  write: [6:0] row, [7] half select; search: [6:0] key, [7] ignored.
REQ-010 in_wdata  input  32  write data.
REQ-011 out_rdata  output  64  registered match vector; bit i = entry i matches key.
REQ-012 out_pma  output  6  priority match address (present only with TCAM_PMA_EN).
REQ-013 out_hit  output  1  any-match flag (present only with TCAM_PMA_EN).

Function
REQ-014 Storage SHALL be ROWS x MATCH_W bits; row k holds, for every entry, whether the entry matches 7-bit key k (ternary pre-expanded in software).
REQ-015 Write (in_csb=0, in_web=0): at the clock edge, row in_addr[6:0] half in_addr[7] (0 = bits 31:0, 1 = bits 63:32) SHALL take in_wdata byte j wherever in_wmask[j]=1; other bytes/half unchanged.
REQ-016 Write with in_wmask=4'b0000 SHALL change no storage.
REQ-017 During a write cycle out_rdata SHALL hold its previous value.
REQ-018 Search (in_csb=0, in_web=1): at the clock edge out_rdata SHALL load the full 64-bit row in_addr[6:0]; latency exactly one cycle; in_addr[7] and in_wdata/in_wmask ignored.
REQ-019 Idle (in_csb=1): no storage change, out_rdata holds.
REQ-020 A search issued the cycle after a write to the same row SHALL return the written data (write visible at the following edge, no bypass needed).
REQ-021 Cascading: wider keys are formed externally by bitwise AND of several instances' out_rdata; the block SHALL add no combinational path from inputs to out_rdata.

Reset
REQ-022 in_rst_n=0 SHALL asynchronously clear out_rdata to 64'h0 and every storage bit to 0 (no entry matches any key).
REQ-023 Reset SHALL override any write/search in progress; first operation is accepted on the first rising edge with in_rst_n=1.

Configuration
REQ-024 Macro TCAM_PMA_EN: when defined, out_pma/out_hit exist and are combinational from out_rdata; when undefined, those ports and the encoder logic are absent and behaviour of all other ports is identical.
REQ-025 With TCAM_PMA_EN, out_pma SHALL equal the index of the lowest-numbered set bit of out_rdata (bit 0 highest priority); out_hit = |out_rdata.
REQ-026 With TCAM_PMA_EN and out_rdata=0, out_pma SHALL be 6'd0 and out_hit 0; after reset out_pma=0, out_hit=0.

Structure
REQ-027 Shared package tcam_pkg SHALL hold ROWS, MATCH_W, DATA_W, ADDR_W=8, PMA_W=6 and typedefs match_vec_t (64 bits) and pma_t (6 bits).
REQ-028 One sub-module, priority_encoder_64x6 (64-bit in, 6-bit out, lowest-index-wins), instantiated only under TCAM_PMA_EN.

Verification
REQ-029 Reset then search key 7'h05 -> out_rdata=64'h0 one cycle later; (PMA_EN) out_hit=0, out_pma=0.
REQ-030 Write row 5 half 0 wdata 32'h0000_0010 wmask 4'hF, write row 5 half 1 wdata 32'h8000_0000 wmask 4'hF, search 8'h85 -> out_rdata=64'h8000_0000_0000_0010; out_pma=6'd4, out_hit=1.
REQ-031 Write row 9 half 0 wdata 32'hAABB_CCDD wmask 4'b0101 over zeros -> search 9 gives 64'h0000_0000_00BB_00DD.
REQ-032 in_csb=1 with in_web=0, any data -> storage and out_rdata unchanged on subsequent search of same row.
REQ-033 Assert in_rst_n=0 mid-cycle after a populated search -> out_rdata=0 immediately without clock; later searches return 0.
REQ-034 Two instances, rows ANDed externally (64'hF0 & 64'h30) -> combined vector 64'h30, encoder out_pma=6'd4.

Source files
------------

// File: rtl/tcam_pkg.sv
// tcam_pkg: shared sizes, types and byte-lane helper for the 7-bit-key x 64-entry TCAM
package tcam_pkg;
    localparam int ROWS    = 128;
    localparam int MATCH_W = 64;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 8;
    localparam int PMA_W   = 6;

    typedef logic [MATCH_W-1:0] match_vec_t;
    typedef logic [PMA_W-1:0]   pma_t;

    // Expand a 4-bit byte mask into a 64-bit bit mask positioned on the selected half-row
    function automatic match_vec_t lane_bits(input logic half, input logic [3:0] wmask);
        logic [7:0] lanes;
        lanes = half ? {wmask, 4'h0} : {4'h0, wmask};
        for (int j = 0; j < 8; j++) lane_bits[j*8 +: 8] = {8{lanes[j]}};
    endfunction
endpackage

// File: rtl/priority_encoder_64x6.sv
// priority_encoder_64x6: index of the lowest set bit of a 64-bit vector (0 when empty)
module priority_encoder_64x6
    import tcam_pkg::*;
(
    input  match_vec_t in_vec,
    output pma_t       out_idx
);
    // Scan from the top down so the lowest set bit is the last to win
    always_comb begin
        out_idx = '0;
        for (int i = MATCH_W - 1; i >= 0; i--) if (in_vec[i]) out_idx = PMA_W'(i);
    end
endmodule

// File: rtl/tcam_7x64.sv
// tcam_7x64: 128-row x 64-entry pre-expanded TCAM; define TCAM_PMA_EN to add out_pma/out_hit
module tcam_7x64
    import tcam_pkg::*;
(
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_csb,
    input  logic              in_web,
    input  logic [3:0]        in_wmask,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    output match_vec_t        out_rdata
`ifdef TCAM_PMA_EN
    ,
    output pma_t              out_pma,
    output logic              out_hit
`endif
);
    match_vec_t mem [ROWS];
    match_vec_t bit_en;
    match_vec_t wr_row;
    logic [6:0] row;

    assign row = in_addr[6:0];

    // Merge masked write data into the addressed row's current contents
    always_comb begin
        bit_en = lane_bits(in_addr[7], in_wmask);
        wr_row = ({2{in_wdata}} & bit_en) | (mem[row] & ~bit_en);
    end

    // Storage writes and registered search result; reset clears everything
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int r = 0; r < ROWS; r++) mem[r] <= '0;
            out_rdata <= '0;
        end else if (!in_csb) begin
            if (!in_web) mem[row] <= wr_row;
            else out_rdata <= mem[row];
        end
    end

`ifdef TCAM_PMA_EN
    priority_encoder_64x6 u_pe (
        .in_vec (out_rdata),
        .out_idx(out_pma)
    );
    assign out_hit = |out_rdata;
`endif
endmodule

// File: tb/tb_tcam_7x64.sv
// tb_tcam_7x64: directed and randomized checks of tcam_7x64 against an array model
module tb_tcam_7x64;
    logic        in_clk = 0;
    logic        in_rst_n = 0;
    logic        in_csb = 1;
    logic        in_web = 1;
    logic [3:0]  in_wmask = 0;
    logic [7:0]  in_addr = 0;
    logic [31:0] in_wdata = 0;
    logic [63:0] out_rdata;
`ifdef TCAM_PMA_EN
    logic [5:0]  out_pma;
    logic        out_hit;
    logic [63:0] casc;
    logic [5:0]  casc_pma;
`endif

    logic [63:0] model [128];
    logic [63:0] exp_rdata;
    int vectors = 0;
    int miscompares = 0;

    tcam_7x64 u_dut (
        .in_clk  (in_clk),
        .in_rst_n(in_rst_n),
        .in_csb  (in_csb),
        .in_web  (in_web),
        .in_wmask(in_wmask),
        .in_addr (in_addr),
        .in_wdata(in_wdata),
        .out_rdata(out_rdata)
`ifdef TCAM_PMA_EN
        ,
        .out_pma (out_pma),
        .out_hit (out_hit)
`endif
    );

`ifdef TCAM_PMA_EN
    priority_encoder_64x6 u_casc_pe (.in_vec(casc), .out_idx(casc_pma));
`endif

    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int low_idx(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic check_out(input string tag);
        check(tag, out_rdata, exp_rdata);
`ifdef TCAM_PMA_EN
        check({tag, "_pma"}, 64'(out_pma), 64'(low_idx(exp_rdata)));
        check({tag, "_hit"}, 64'(out_hit), 64'(exp_rdata != 0));
`endif
    endtask

    task automatic model_reset();
        for (int r = 0; r < 128; r++) model[r] = 0;
        exp_rdata = 0;
    endtask

    // One operation: drive at negedge, model at posedge, check at next negedge
    task automatic op(input logic csb, input logic web, input logic [7:0] addr,
                      input logic [3:0] wmask, input logic [31:0] wdata, input string tag);
        int base;
        in_csb = csb; in_web = web; in_addr = addr; in_wmask = wmask; in_wdata = wdata;
        @(posedge in_clk);
        base = addr[7] ? 32 : 0;
        if (!csb) begin
            if (!web) begin
                for (int b = 0; b < 4; b++)
                    if (wmask[b]) model[addr[6:0]][base + b*8 +: 8] = wdata[b*8 +: 8];
            end else exp_rdata = model[addr[6:0]];
        end
        @(negedge in_clk);
        check_out(tag);
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
        op(0, 0, a, m, d, "write_hold");
    endtask

    task automatic rd(input logic [7:0] a, input string tag);
        op(0, 1, a, 4'h0, 32'h0, tag);
    endtask

    logic [63:0] r20, r21;

    initial begin
        model_reset();
        #1 check_out("reset");
        @(negedge in_clk);
        in_rst_n = 1;

        rd(8'h05, "search_after_reset");
        wr(8'h05, 4'hF, 32'h0000_0010);
        wr(8'h85, 4'hF, 32'h8000_0000);
        rd(8'h85, "row5_full");
        check("row5_const", out_rdata, 64'h8000_0000_0000_0010);
        wr(8'h09, 4'b0101, 32'hAABB_CCDD);
        rd(8'h09, "row9_mask");
        check("row9_const", out_rdata, 64'h0000_0000_00BB_00DD);
        wr(8'h09, 4'b0000, 32'hFFFF_FFFF);
        rd(8'h89, "row9_hi_zero");
        rd(8'h09, "zero_mask");
        op(1, 0, 8'h05, 4'hF, 32'h1234_5678, "idle_write");
        op(1, 1, 8'h09, 4'hF, 32'h0, "idle_hold");
        rd(8'h05, "idle_no_store");
        wr(8'h7F, 4'hF, 32'hDEAD_BEEF);
        rd(8'h7F, "back_to_back");

        wr(8'h14, 4'hF, 32'h0000_00F0);
        rd(8'h14, "casc_a");
        r20 = out_rdata;
        wr(8'h15, 4'hF, 32'h0000_0030);
        rd(8'h15, "casc_b");
        r21 = out_rdata;
        check("cascade_and", r20 & r21, 64'h30);
`ifdef TCAM_PMA_EN
        casc = r20 & r21;
        #1 check("cascade_pma", 64'(casc_pma), 64'd4);
`endif

        for (int n = 0; n < 400; n++) begin
            op(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
               {1'($urandom_range(0, 1)), 7'($urandom_range(0, 15))},
               4'($urandom), $urandom, "random");
        end

        rd(8'h85, "pre_reset");
        #1 in_rst_n = 0;
        model_reset();
        #1 check_out("async_reset");
        @(posedge in_clk);
        @(negedge in_clk);
        in_rst_n = 1;
        rd(8'h05, "post_reset_row5");
        rd(8'h7F, "post_reset_row127");
        for (int k = 0; k < 16; k++) rd(8'(k), "post_reset_sweep");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
